// File: rtl/nios0_ip_nios2_gen2_0_cpu_ocimem_arbiter_pkg.sv
// Shared types and jdo field positions for the OCI debug RAM arbiter.
package nios0_ip_nios2_gen2_0_cpu_ocimem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CPU_RDW = 2'd1,
    ST_DBG_RDW = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CMD_NONE  = 2'd0,
    CMD_READ  = 2'd1,
    CMD_WRITE = 2'd2
  } cmd_t;

  localparam int unsigned ADDR_LSB   = 26;
  localparam int unsigned RD_BIT     = 34;
  localparam int unsigned ERRCLR_BIT = 35;
  localparam int unsigned LOAD_BIT   = 17;
  localparam int unsigned WDATA_MSB  = 34;
  localparam int unsigned WDATA_LSB  = 3;

endpackage

// File: rtl/nios0_ip_nios2_gen2_0_cpu_ocimem_arbiter_if.sv
// CPU-side debug memory slave bus shared by the CPU master and the arbiter.
interface nios0_ip_nios2_gen2_0_cpu_ocimem_arbiter_if #(
  parameter int unsigned ADDR_W = 8
) ();
  logic [ADDR_W-1:0] cpu_address;
  logic              cpu_read;
  logic              cpu_write;
  logic [31:0]       cpu_writedata;
  logic [3:0]        cpu_byteenable;
  logic [31:0]       cpu_readdata;
  logic              cpu_waitrequest;

  modport master (
    output cpu_address, cpu_read, cpu_write, cpu_writedata, cpu_byteenable,
    input  cpu_readdata, cpu_waitrequest
  );

  modport slave (
    input  cpu_address, cpu_read, cpu_write, cpu_writedata, cpu_byteenable,
    output cpu_readdata, cpu_waitrequest
  );
endinterface

// File: rtl/nios0_ip_nios2_gen2_0_cpu_ocimem_cmd_slot.sv
// JTAG strobe decode, one-deep command slot, overflow flag and debug address.
module nios0_ip_nios2_gen2_0_cpu_ocimem_cmd_slot
  import nios0_ip_nios2_gen2_0_cpu_ocimem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic              done,
  output logic              pend_valid,
  output cmd_t              pend_op,
  output logic [31:0]       pend_wdata,
  output logic [ADDR_W-1:0] dbg_addr,
  output logic              monitor_ready,
  output logic              monitor_error
);

  cmd_t new_op;
  logic unused_jdo;

  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

  always_comb begin
    new_op = CMD_NONE;
    if (take_action_ocimem_b)
      new_op = CMD_WRITE;
    else if ((take_action_ocimem_a && jdo[RD_BIT]) || take_no_action_ocimem_a)
      new_op = CMD_READ;
  end

  // Address load is ordered after the completion increment so a load wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_valid    <= 1'b0;
      pend_op       <= CMD_NONE;
      pend_wdata    <= '0;
      dbg_addr      <= '0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
    end else begin
      if (done) begin
        pend_valid    <= 1'b0;
        pend_op       <= CMD_NONE;
        monitor_ready <= 1'b1;
        dbg_addr      <= dbg_addr + 1'b1;
      end
      if (take_action_ocimem_a && jdo[LOAD_BIT])
        dbg_addr <= jdo[ADDR_LSB +: ADDR_W];
      if (take_action_ocimem_a && jdo[ERRCLR_BIT])
        monitor_error <= 1'b0;
      if (new_op != CMD_NONE) begin
        if (pend_valid) begin
          monitor_error <= 1'b1;
        end else begin
          pend_valid    <= 1'b1;
          pend_op       <= new_op;
          pend_wdata    <= jdo[WDATA_MSB:WDATA_LSB];
          monitor_ready <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/nios0_ip_nios2_gen2_0_cpu_ocimem_arbiter.sv
// Arbitrates the single-port OCI debug RAM between the CPU slave and JTAG commands.
module nios0_ip_nios2_gen2_0_cpu_ocimem_arbiter
  import nios0_ip_nios2_gen2_0_cpu_ocimem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  nios0_ip_nios2_gen2_0_cpu_ocimem_arbiter_if.slave cpu,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wren,
  output logic [3:0]        ram_byteenable,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  state_t            state;
  logic              last_dbg;
  logic              pend_valid;
  cmd_t              pend_op;
  logic [31:0]       pend_wdata;
  logic [ADDR_W-1:0] dbg_addr;
  logic              cpu_req;
  logic              dbg_grant;
  logic              dbg_done;
  logic              cpu_done;

  nios0_ip_nios2_gen2_0_cpu_ocimem_cmd_slot #(.ADDR_W(ADDR_W)) u_slot (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .done                    (dbg_done),
    .pend_valid              (pend_valid),
    .pend_op                 (pend_op),
    .pend_wdata              (pend_wdata),
    .dbg_addr                (dbg_addr),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error)
  );

  // RAM port is driven combinationally from IDLE so a granted write lands the same cycle.
  always_comb begin
    cpu_req        = cpu.cpu_read | cpu.cpu_write;
    dbg_grant      = (state == ST_IDLE) && pend_valid && (!last_dbg || !cpu_req);
    ram_addr       = cpu.cpu_address;
    ram_wren       = 1'b0;
    ram_byteenable = cpu.cpu_byteenable;
    ram_wdata      = cpu.cpu_writedata;
    dbg_done       = 1'b0;
    cpu_done       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (dbg_grant) begin
          ram_addr = dbg_addr;
          if (pend_op == CMD_WRITE) begin
            ram_wren       = 1'b1;
            ram_byteenable = '1;
            ram_wdata      = pend_wdata;
            dbg_done       = 1'b1;
          end
        end else if (cpu.cpu_write && !cpu.cpu_read) begin
          ram_wren = 1'b1;
          cpu_done = 1'b1;
        end
      end
      ST_DBG_RDW: dbg_done = 1'b1;
      ST_CPU_RDW: cpu_done = 1'b1;
      default: ;
    endcase
    if (reset) begin
      ram_wren = 1'b0;
      dbg_done = 1'b0;
      cpu_done = 1'b0;
    end
  end

  assign cpu.cpu_waitrequest = reset | (cpu_req & ~cpu_done);
  assign cpu.cpu_readdata    = (state == ST_CPU_RDW) ? ram_rdata : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      last_dbg <= 1'b0;
      MonDReg  <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (dbg_grant) begin
            last_dbg <= 1'b1;
            if (pend_op == CMD_READ) state <= ST_DBG_RDW;
          end else if (cpu.cpu_read) begin
            last_dbg <= 1'b0;
            state    <= ST_CPU_RDW;
          end else if (cpu.cpu_write) begin
            last_dbg <= 1'b0;
          end
        end
        ST_DBG_RDW: begin
          MonDReg <= ram_rdata;
          state   <= ST_IDLE;
        end
        ST_CPU_RDW: state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/nios0_ip_nios2_gen2_0_cpu_ocimem_arbiter.md
# nios0_ip_nios2_gen2_0_cpu_ocimem_arbiter

Arbitrates the single-port on-chip instruction memory (OCI debug RAM) between the CPU-side debug memory slave and JTAG debug commands decoded on the system clock. The block consumes `jdo` and the `take_action_ocimem_*` strobes from the sysclk half of the debug slave. It sequences RAM reads and writes through a one-deep command slot and an auto-incrementing address. It returns `MonDReg`, `monitor_ready` and `monitor_error` to the debug slave for TCK-side capture.

## Interface
- `ADDR_W`, 8, RAM word-address width (256 × 32-bit words).
- `clk` in 1: system clock; the only clock.
- `reset` in 1: synchronous, active-high.
- `jdo` in 38: JTAG data-out register.
- `take_action_ocimem_a` in 1: one-cycle strobe; address load, optional read, optional error clear.
- `take_action_ocimem_b` in 1: one-cycle strobe; write `jdo[34:3]`.
- `take_no_action_ocimem_a` in 1: one-cycle strobe; streaming read at the current address.
- `cpu_address` in ADDR_W: CPU word address.
- `cpu_read`, `cpu_write` in 1: CPU requests, held until `cpu_waitrequest`=0.
- `cpu_writedata` in 32 / `cpu_byteenable` in 4: CPU write data and byte enables.
- `cpu_readdata` out 32: CPU read data.
- `cpu_waitrequest` out 1: CPU stall.
- `ram_addr` out ADDR_W, `ram_wren` out 1, `ram_byteenable` out 4, `ram_wdata` out 32: RAM port.
- `ram_rdata` in 32: RAM read data, valid one cycle after address (synchronous read).
- `MonDReg` out 32: last debug read data.
- `monitor_ready` out 1: last debug command completed.
- `monitor_error` out 1: sticky command-overflow flag.

## Operation
- Command decode, one cycle after the strobe:
  - `take_action_ocimem_a`: if `jdo[17]`, load `dbg_addr <= jdo[25+ADDR_W:26]`. If `jdo[34]`, queue a READ; the read uses the newly loaded address. If `jdo[35]`, clear `monitor_error`.
  - `take_action_ocimem_b`: queue a WRITE of `jdo[34:3]` with byte enables 4'hF.
  - `take_no_action_ocimem_a`: queue a READ at `dbg_addr`.
- Command slot:
  - One entry; `pend_valid` is sampled at the start of the cycle.
  - A strobe arriving while `pend_valid`=1 sets `monitor_error`, and the command is dropped. This holds even if the pending command completes in that same cycle.
  - The address-load and error-clear side effects still apply.
- Accepting a command clears `monitor_ready`.
- FSM states: IDLE, CPU_RDW, DBG_RDW. Arbitration happens in IDLE only; a granted access is never preempted.
  - Pending debug command, and either `last_dbg`=0 or no CPU request: grant debug.
    - WRITE: `ram_wren`=1 this cycle. Next cycle `monitor_ready`=1, `dbg_addr`+1, slot freed.
    - READ: drive `ram_addr`, go to DBG_RDW.
  - Otherwise, `cpu_read`: drive `ram_addr`, go to CPU_RDW.
  - Otherwise, `cpu_write`: `ram_wren`=1, `cpu_waitrequest`=0 this cycle.
  - DBG_RDW: `MonDReg <= ram_rdata`, `monitor_ready <= 1`, `dbg_addr`+1, slot freed, back to IDLE.
  - CPU_RDW: `cpu_readdata = ram_rdata`, `cpu_waitrequest`=0, back to IDLE.
- `last_dbg` is set on a debug grant and cleared on a CPU grant. This alternation guarantees the CPU is never starved by streaming debug commands.
- `dbg_addr` wraps modulo 2^ADDR_W (0xFF+1 → 0x00).
- `cpu_waitrequest` = (`cpu_read`|`cpu_write`) & ~completing-this-cycle. It is forced to 1 during `reset`.

## Timing
- Reset values: FSM=IDLE, `pend_valid`=0, `dbg_addr`=0, `last_dbg`=0, `MonDReg`=0, `monitor_ready`=0, `monitor_error`=0, `ram_wren`=0, `cpu_readdata`=0.
- Uncontended debug write, strobe in cycle T: RAM write at T+1; `monitor_ready`=1 and incremented address visible at T+2.
- Uncontended debug read, strobe in cycle T: address at T+1, data at T+2; `MonDReg` and `monitor_ready`=1 visible at T+3.
- CPU read: 2 cycles (waitrequest high in cycle 1). CPU write: 1 cycle. Each adds at most one debug access of delay when contended.
- `reset` mid-access aborts it; the pending command is discarded and no RAM write occurs in the reset cycle.

## Structure
- A shared package holds:
  - the state enum;
  - the command opcode constants (NONE/READ/WRITE);
  - the `jdo` field positions (ADDR_LSB=26, RD_BIT=34, ERRCLR_BIT=35, LOAD_BIT=17, WDATA 34:3).
- One sub-module, `nios0_ip_nios2_gen2_0_cpu_ocimem_cmd_slot`: strobe decode, pending slot, overflow/error logic and `dbg_addr`.
- Arbitration, the FSM and RAM muxing stay in the top level.

## Test plan
- Load 0x10 via `ocimem_a` (`jdo[17]`=1), then `ocimem_b` with data 0xDEADBEEF → RAM[0x10]=0xDEADBEEF, `dbg_addr`=0x11, `monitor_ready`=1 at T+2.
- `ocimem_a` with load 0x10 and `jdo[34]`=1 → `MonDReg`=0xDEADBEEF at T+3; two `take_no_action_ocimem_a` strobes read 0x11 then 0x12.
- Address 0xFF, then a write → `dbg_addr`=0x00.
- Second strobe while pending → `monitor_error`=1 and the command is dropped; `ocimem_a` with `jdo[35]`=1 → error=0.
- CPU read held continuously while debug reads stream → grants alternate, the CPU completes within 4 cycles, and both data paths are correct.
- `reset` asserted in DBG_RDW → all outputs return to reset values next cycle; `monitor_ready` stays 0.
